// File: rtl/blackjack_action_input.sv
// Blackjack input front-end: debounced buttons and PS/2 scan codes merged into
// one ordered valid/ready action stream, with typematic suppression and overflow flag.

module bja_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_s1, r_s2, r_db;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_s2 != r_db) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Only the released->pressed edge is an event; release is silent.
  assign o_press  = w_accept & ~r_s2;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module blackjack_action_input #(
  parameter int NUM_SEATS       = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic [2:0]                    key_n,
  input  logic [1:0]                    key_seat,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_data_en,
  output logic                          act_valid,
  input  logic                          act_ready,
  output logic [1:0]                    act_code,
  output logic [1:0]                    act_seat,
  output logic                          act_src,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0]   NS      = 3'(NUM_SEATS);
  localparam logic [AW:0]  DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] seat;
    logic       src;
  } act_t;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} ps2_st_t;

  // {valid, seat[1:0], action[1:0]}
  function automatic logic [4:0] map_code(input logic [7:0] b);
    case (b)
      8'h33: map_code = {1'b1, 2'd0, 2'd0};
      8'h1B: map_code = {1'b1, 2'd0, 2'd1};
      8'h23: map_code = {1'b1, 2'd0, 2'd2};
      8'h3B: map_code = {1'b1, 2'd1, 2'd0};
      8'h42: map_code = {1'b1, 2'd1, 2'd1};
      8'h4B: map_code = {1'b1, 2'd1, 2'd2};
      8'h16: map_code = {1'b1, 2'd2, 2'd0};
      8'h1E: map_code = {1'b1, 2'd2, 2'd1};
      8'h26: map_code = {1'b1, 2'd2, 2'd2};
      8'h25: map_code = {1'b1, 2'd3, 2'd0};
      8'h2E: map_code = {1'b1, 2'd3, 2'd1};
      8'h36: map_code = {1'b1, 2'd3, 2'd2};
      default: map_code = 5'd0;
    endcase
  endfunction

  // ---------------- buttons ----------------
  logic [2:0] w_press;
  logic [2:0] r_pend;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_btn
      bja_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .i_key_n  (key_n[g]),
        .o_press  (w_press[g])
      );
    end
  endgenerate

  // ---------------- PS/2 decoder ----------------
  ps2_st_t     r_st, w_st_nxt;
  logic [11:0] r_held, w_held_nxt;
  logic        r_ps2_wr, w_dec_wr;
  act_t        r_ps2_act;
  logic [4:0]  w_map;
  logic        w_map_ok;
  logic [3:0]  w_idx;

  assign w_map    = map_code(ps2_data);
  assign w_map_ok = w_map[4] && ({1'b0, w_map[3:2]} < NS);
  assign w_idx    = {2'b0, w_map[3:2]} * 4'd3 + {2'b0, w_map[1:0]};

  always_comb begin
    w_st_nxt   = r_st;
    w_held_nxt = r_held;
    w_dec_wr   = 1'b0;
    if (ps2_data_en) begin
      case (r_st)
        S_IDLE: begin
          if (ps2_data == 8'hF0)      w_st_nxt = S_BREAK;
          else if (ps2_data == 8'hE0) w_st_nxt = S_EXT;
          else if (w_map_ok && !r_held[w_idx]) begin
            w_dec_wr          = 1'b1;
            w_held_nxt[w_idx] = 1'b1;
          end
        end
        S_BREAK: begin
          if (w_map_ok) w_held_nxt[w_idx] = 1'b0;
          w_st_nxt = S_IDLE;
        end
        S_EXT:   w_st_nxt = (ps2_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: w_st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      r_held    <= '0;
      r_ps2_wr  <= 1'b0;
      r_ps2_act <= '0;
    end else begin
      r_st      <= w_st_nxt;
      r_held    <= w_held_nxt;
      r_ps2_wr  <= w_dec_wr;
      r_ps2_act <= '{code: w_map[1:0], seat: w_map[3:2], src: 1'b1};
    end
  end

  // ---------------- merge: PS/2 has priority, buttons drain lowest first ----------------
  logic       w_btn_wr, w_seat_ok;
  logic [2:0] w_btn_sel;
  logic [1:0] w_btn_code;

  assign w_seat_ok  = ({1'b0, key_seat} < NS);
  assign w_btn_wr   = !r_ps2_wr && (|r_pend);
  assign w_btn_sel  = r_pend & 3'(~r_pend + 3'd1);
  assign w_btn_code = r_pend[0] ? 2'd0 : (r_pend[1] ? 2'd1 : 2'd2);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~(w_btn_wr ? w_btn_sel : 3'b0)) | (w_seat_ok ? w_press : 3'b0);
  end

  // ---------------- FWFT FIFO ----------------
  act_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_wr, w_pop, w_acc;
  act_t          w_wdata, w_head;

  assign w_wr    = r_ps2_wr | w_btn_wr;
  assign w_wdata = r_ps2_wr ? r_ps2_act : '{code: w_btn_code, seat: key_seat, src: 1'b0};
  assign w_pop   = act_valid & act_ready;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign w_acc   = w_wr && ((r_cnt != DEPTH_C) || w_pop);

  always_ff @(posedge CLOCK_50) begin
    if (w_acc) r_mem[r_wp] <= w_wdata;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_wr && !w_acc) r_ovf <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rp];
  assign act_valid  = (r_cnt != '0);
  assign act_code   = act_valid ? w_head.code : 2'd0;
  assign act_seat   = act_valid ? w_head.seat : 2'd0;
  assign act_src    = act_valid ? w_head.src  : 1'b0;
  assign fifo_count = r_cnt;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_blackjack_action_input.sv
// Scoreboard bench for blackjack_action_input: expected actions queued at stimulus
// time, popped and compared on every accepted head.

module tb_blackjack_action_input;
  logic       CLOCK_50, rst_n;
  logic [2:0] key_n;
  logic [1:0] key_seat;
  logic [7:0] ps2_data;
  logic       ps2_data_en, act_valid, act_ready, act_src, overflow;
  logic [1:0] act_code, act_seat;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] sb_q [$];

  blackjack_action_input #(.NUM_SEATS(2), .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .key_n(key_n), .key_seat(key_seat),
    .ps2_data(ps2_data), .ps2_data_en(ps2_data_en), .act_valid(act_valid),
    .act_ready(act_ready), .act_code(act_code), .act_seat(act_seat), .act_src(act_src),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_data    = b;
    ps2_data_en = 1'b1;
    tick();
    ps2_data_en = 1'b0;
  endtask

  // expected entry packed {code, seat, src}
  task automatic expect_act(input int code, input int seat, input int src);
    sb_q.push_back({2'(code), 2'(seat), 1'(src)});
  endtask

  task automatic drain();
    act_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fifo_count == 0) break;
    end
    act_ready = 1'b0;
    chk("drain_empty", int'(fifo_count), 0);
    chk("sb_consumed", sb_q.size(), 0);
  endtask

  always @(negedge CLOCK_50) begin
    if (rst_n && act_valid && act_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("act_head", int'({act_code, act_seat, act_src}), int'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0; key_n = 3'b111; key_seat = 2'd0;
    ps2_data = 8'h00; ps2_data_en = 1'b0; act_ready = 1'b0;
    #2;
    chk("rst_valid", int'(act_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf",   int'(overflow), 0);
    chk("rst_head",  int'({act_code, act_seat, act_src}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // PS/2 hit seat 0 with its break: exactly one entry
    send(8'h33); send(8'hF0); send(8'h33);
    tick(); tick();
    chk("hit_count", int'(fifo_count), 1);
    chk("hit_head",  int'({act_code, act_seat, act_src}), int'({2'd0, 2'd0, 1'b1}));
    expect_act(0, 0, 1);
    drain();

    // Typematic repeats, extended codes, unpopulated seat
    send(8'h42); send(8'h42); send(8'h42); send(8'hF0); send(8'h42); send(8'h42);
    send(8'hE0); send(8'h33); send(8'hE0); send(8'hF0); send(8'h33);
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'hF0); send(8'h42);
    tick(); tick();
    chk("typ_count", int'(fifo_count), 2);
    expect_act(1, 1, 1); expect_act(1, 1, 1);
    drain();

    // Debounce: short glitch ignored
    key_seat = 2'd1;
    key_n[2] = 1'b0; repeat (5) tick(); key_n[2] = 1'b1;
    repeat (20) tick();
    chk("glitch_count", int'(fifo_count), 0);

    // Debounce: long press, latency from first low sample
    lat = 0;
    key_n[2] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (act_valid && lat == 0) lat = c;
    end
    key_n[2] = 1'b1;
    chk("deb_latency", lat, 11);
    repeat (15) tick();
    chk("deb_count", int'(fifo_count), 1);
    expect_act(2, 1, 0);
    drain();

    // Button on an unpopulated seat is dropped
    key_seat = 2'd2;
    key_n[0] = 1'b0; repeat (15) tick(); key_n[0] = 1'b1;
    repeat (15) tick();
    chk("badseat_count", int'(fifo_count), 0);
    key_seat = 2'd0;

    // Collision: three buttons debounce on the edge that samples PS/2 deal
    key_n = 3'b000;
    repeat (9) tick();
    send(8'h23);
    expect_act(2, 0, 1); expect_act(0, 0, 0); expect_act(1, 0, 0); expect_act(2, 0, 0);
    repeat (5) tick();
    key_n = 3'b111;
    send(8'hF0); send(8'h23);
    repeat (15) tick();
    chk("coll_count", int'(fifo_count), 4);
    chk("coll_ovf",   int'(overflow), 0);
    drain();

    // Overflow: five distinct makes into a depth-4 FIFO
    send(8'h33); send(8'h1B); send(8'h23); send(8'h3B); send(8'h4B);
    expect_act(0, 0, 1); expect_act(1, 0, 1); expect_act(2, 0, 1); expect_act(0, 1, 1);
    tick(); tick();
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_flag",  int'(overflow), 1);
    // Sixth make lands in the same cycle as a pop
    ps2_data = 8'h42; ps2_data_en = 1'b1;
    tick();
    ps2_data_en = 1'b0; act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    expect_act(1, 1, 1);
    chk("ovf_pop_count", int'(fifo_count), 4);
    chk("ovf_sticky",    int'(overflow), 1);

    // Reset mid-stream: 3 queued, decoder in BREAK
    act_ready = 1'b1; tick(); act_ready = 1'b0;
    chk("pre_rst_count", int'(fifo_count), 3);
    send(8'hF0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(act_valid), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ovf",   int'(overflow), 0);
    chk("mid_rst_head",  int'({act_code, act_seat, act_src}), 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h33);
    tick(); tick();
    chk("post_rst_count", int'(fifo_count), 1);
    expect_act(0, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
